// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
// Bundles the ID-stage instruction attributes, pipeline control inputs and
// hazard-control outputs of pipe_hazard_ctrl into one port.
//   master : the pipeline side; drives the ID fields and the control inputs,
//            and receives the stall/bubble/flush/forward/counter outputs.
//   slave  : the hazard controller itself.
// Parameters must match those of the pipe_hazard_ctrl instance it connects to.
interface pipe_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int DEPTH = 3,
    parameter int CNT_W = 32
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    // ID-stage instruction attributes
    logic             id_valid;
    logic             id_wb_en;
    logic             id_is_load;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic [RA_W-1:0]  id_rd;

    // pipeline control inputs
    logic             ex_branch_taken;
    logic             ext_stall;
    logic             cnt_clr;

    // hazard-control outputs
    logic             stall_if_id;
    logic             bubble_ex;
    logic             flush;
    logic [SEL_W-1:0] fwd_rs1_sel;
    logic [SEL_W-1:0] fwd_rs2_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_wb_en, id_is_load, id_rs1_used, id_rs2_used,
        output id_rs1, id_rs2, id_rd,
        output ex_branch_taken, ext_stall, cnt_clr,
        input  stall_if_id, bubble_ex, flush, fwd_rs1_sel, fwd_rs2_sel,
        input  stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_wb_en, id_is_load, id_rs1_used, id_rs2_used,
        input  id_rs1, id_rs2, id_rd,
        input  ex_branch_taken, ext_stall, cnt_clr,
        output stall_if_id, bubble_ex, flush, fwd_rs1_sel, fwd_rs2_sel,
        output stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Pipeline hazard controller. Keeps a shadow copy {valid, rd, wb_en, is_load}
// of every instruction in the DEPTH stages after ID (1 = EX, 2 = MEM, ...),
// and from it derives, in the same cycle as the ID inputs:
//   - forwarding selects for both ID sources (youngest producer wins),
//   - load-use stall + bubble when a load's data is not yet forwardable,
//   - flush on a taken branch in EX,
// together with saturating load-use-stall and flush event counters.
// Ports:
//   clk : clock, all state on the rising edge
//   rst : asynchronous, active-low reset; forces every output to 0
//   bus : pipe_hazard_ctrl_if.slave (ID fields, controls, hazard outputs)
// Priority of pipeline actions: ext_stall > flush > load-use.
module pipe_hazard_ctrl #(
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_RDY = 2,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int               SEL_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // shadow entries, index k mirrors pipeline stage k
    logic [DEPTH:1]  ent_valid_reg;
    logic [DEPTH:1]  ent_wb_en_reg;
    logic [DEPTH:1]  ent_is_load_reg;
    logic [RA_W-1:0] ent_rd_reg [1:DEPTH];

    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    logic [DEPTH:1]   rs1_hit;
    logic [DEPTH:1]   rs2_hit;
    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic             rs1_ld_early;
    logic             rs2_ld_early;
    logic             load_use;
    logic             do_flush;
    logic             do_bubble;
    logic             kill_id;

    // per-stage producer match for each source
    generate
        for (genvar gi = 1; gi <= DEPTH; gi++) begin : g_match
            assign rs1_hit[gi] = bus.id_rs1_used && ent_valid_reg[gi] && ent_wb_en_reg[gi]
                               && (ent_rd_reg[gi] != '0) && (ent_rd_reg[gi] == bus.id_rs1);
            assign rs2_hit[gi] = bus.id_rs2_used && ent_valid_reg[gi] && ent_wb_en_reg[gi]
                               && (ent_rd_reg[gi] != '0) && (ent_rd_reg[gi] == bus.id_rs2);
        end
    endgenerate

    // Scan oldest to youngest so the youngest hit is the last one written.
    // A hit is "early" when it is a load whose data is not yet available.
    always_comb begin
        rs1_sel      = '0;
        rs2_sel      = '0;
        rs1_ld_early = 1'b0;
        rs2_ld_early = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (rs1_hit[k]) begin
                rs1_sel      = SEL_W'(k);
                rs1_ld_early = ent_is_load_reg[k] && (k < LOAD_RDY);
            end
            if (rs2_hit[k]) begin
                rs2_sel      = SEL_W'(k);
                rs2_ld_early = ent_is_load_reg[k] && (k < LOAD_RDY);
            end
        end
    end

    assign load_use  = bus.id_valid && (rs1_ld_early || rs2_ld_early);
    assign do_flush  = !bus.ext_stall && bus.ex_branch_taken;
    assign do_bubble = !bus.ext_stall && !bus.ex_branch_taken && load_use;
    assign kill_id   = do_flush || do_bubble;

    // Outputs are gated with rst so they drop the moment reset is asserted,
    // independent of whatever the ID/control inputs are doing.
    assign bus.stall_if_id = rst && (bus.ext_stall || do_bubble);
    assign bus.bubble_ex   = rst && do_bubble;
    assign bus.flush       = rst && do_flush;
    assign bus.fwd_rs1_sel = (rst && !do_bubble) ? rs1_sel : '0;
    assign bus.fwd_rs2_sel = (rst && !do_bubble) ? rs2_sel : '0;
    assign bus.stall_cnt   = stall_cnt_reg;
    assign bus.flush_cnt   = flush_cnt_reg;

    // Shadow pipeline: frozen under ext_stall, otherwise advances one stage
    // per edge. Entry 1 gets the ID instruction unless it is being killed by
    // a flush or replaced by a load-use bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent_valid_reg   <= '0;
            ent_wb_en_reg   <= '0;
            ent_is_load_reg <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                ent_rd_reg[k] <= '0;
            end
        end else if (!bus.ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) begin
                ent_valid_reg[k]   <= ent_valid_reg[k-1];
                ent_wb_en_reg[k]   <= ent_wb_en_reg[k-1];
                ent_is_load_reg[k] <= ent_is_load_reg[k-1];
                ent_rd_reg[k]      <= ent_rd_reg[k-1];
            end
            ent_valid_reg[1]   <= bus.id_valid && !kill_id;
            ent_wb_en_reg[1]   <= bus.id_wb_en;
            ent_is_load_reg[1] <= bus.id_is_load;
            ent_rd_reg[1]      <= bus.id_rd;
        end
    end

    // Saturating event counters; a clear wins over a same-cycle increment.
    // do_bubble/do_flush are already zero under ext_stall, which holds them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (bus.cnt_clr) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (do_bubble && (stall_cnt_reg != CNT_MAX)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
            if (do_flush && (flush_cnt_reg != CNT_MAX)) begin
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (CNT_W=4 build so saturation is
// reachable). Directed scenarios plus a randomized run against a reference
// model that tracks the pipeline as a list of in-flight instructions.
module tb_pipe_hazard_ctrl;
    localparam int RA_W     = 5;
    localparam int DEPTH    = 3;
    localparam int LOAD_RDY = 2;
    localparam int CNT_W    = 4;
    localparam int SEL_W    = $clog2(DEPTH + 1);
    localparam int CMAX     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] rd;
        logic            wb;
        logic            ld;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RA_W(RA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

    pipe_hazard_ctrl #(.RA_W(RA_W), .DEPTH(DEPTH), .LOAD_RDY(LOAD_RDY), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    ent_t m_pipe [1:DEPTH];
    int   m_scnt;
    int   m_fcnt;
    bit   exp_stall, exp_bubble, exp_flush;
    int   exp_sel1, exp_sel2;

    function automatic void model_clear();
        for (int k = 1; k <= DEPTH; k++) m_pipe[k] = '0;
        m_scnt = 0;
        m_fcnt = 0;
    endfunction

    // stage number of the youngest in-flight writer of src, 0 if none
    function automatic int youngest(logic [RA_W-1:0] src, logic used);
        if (!used || src == 0) return 0;
        for (int k = 1; k <= DEPTH; k++)
            if (m_pipe[k].v && m_pipe[k].wb && m_pipe[k].rd == src) return k;
        return 0;
    endfunction

    function automatic bit not_ready(int p);
        if (p == 0) return 1'b0;
        return m_pipe[p].ld && (p < LOAD_RDY);
    endfunction

    function automatic void model_eval();
        int p1, p2;
        bit lu;
        p1 = youngest(bus.id_rs1, bus.id_rs1_used);
        p2 = youngest(bus.id_rs2, bus.id_rs2_used);
        lu = bus.id_valid && (not_ready(p1) || not_ready(p2));
        exp_stall = 0; exp_bubble = 0; exp_flush = 0; exp_sel1 = 0; exp_sel2 = 0;
        if (!rst) return;
        if (bus.ext_stall) begin
            exp_stall = 1; exp_sel1 = p1; exp_sel2 = p2;
        end else if (bus.ex_branch_taken) begin
            exp_flush = 1; exp_sel1 = p1; exp_sel2 = p2;
        end else if (lu) begin
            exp_stall = 1; exp_bubble = 1;
        end else begin
            exp_sel1 = p1; exp_sel2 = p2;
        end
    endfunction

    function automatic void model_update();
        if (!rst) begin model_clear(); return; end
        model_eval();
        if (bus.cnt_clr) begin
            m_scnt = 0; m_fcnt = 0;
        end else begin
            if (exp_bubble && m_scnt < CMAX) m_scnt++;
            if (exp_flush && m_fcnt < CMAX) m_fcnt++;
        end
        if (!bus.ext_stall) begin
            for (int k = DEPTH; k >= 2; k--) m_pipe[k] = m_pipe[k-1];
            if (exp_flush || exp_bubble) m_pipe[1] = '0;
            else m_pipe[1] = '{v: bus.id_valid, rd: bus.id_rd, wb: bus.id_wb_en, ld: bus.id_is_load};
        end
    endfunction

    task automatic set_id(input bit v, input bit wb, input bit ld, input int rs1, input bit u1,
                          input int rs2, input bit u2, input int rd);
        bus.id_valid = v; bus.id_wb_en = wb; bus.id_is_load = ld;
        bus.id_rs1 = RA_W'(rs1); bus.id_rs1_used = u1;
        bus.id_rs2 = RA_W'(rs2); bus.id_rs2_used = u2;
        bus.id_rd = RA_W'(rd);
    endtask

    task automatic set_ctl(input bit br, input bit es, input bit clr);
        bus.ex_branch_taken = br; bus.ext_stall = es; bus.cnt_clr = clr;
    endtask

    // one clock: model follows the DUT at the rising edge, returns at falling edge
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        set_id(1, 1, 1, 3, 1, 3, 1, 3);
        set_ctl(1, 1, 1);
        repeat (2) @(negedge clk);
        #1;
        $display("reset: outputs while rst=0 with ext_stall/branch driven");
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %0b want 0", bus.stall_if_id); end
        n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL rst_flush: got %0b want 0", bus.flush); end
        n_cmp++; if (bus.bubble_ex !== 1'b0) begin n_err++; $display("FAIL rst_bubble: got %0b want 0", bus.bubble_ex); end
        n_cmp++; if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
        n_cmp++; if (bus.fwd_rs1_sel !== '0 || bus.fwd_rs2_sel !== '0) begin n_err++; $display("FAIL rst_fwd: got %0d/%0d want 0/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        model_clear();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        set_ctl(0, 0, 0);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_forward();
        idle(3);
        set_id(1, 1, 0, 1, 1, 2, 1, 5);           // add x5,x1,x2
        #1;
        $display("forward: add x5");
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL fwd_add_stall: got %0b want 0", bus.stall_if_id); end
        tick();
        set_id(1, 1, 0, 5, 1, 1, 1, 6);           // sub x6,x5,x1
        #1;
        $display("forward: sub x6,x5,x1 sel=%0d/%0d", bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(1)) begin n_err++; $display("FAIL fwd_sub_rs1: got %0d want 1", bus.fwd_rs1_sel); end
        n_cmp++; if (bus.fwd_rs2_sel !== SEL_W'(0)) begin n_err++; $display("FAIL fwd_sub_rs2: got %0d want 0", bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL fwd_sub_stall: got %0b want 0", bus.stall_if_id); end
        tick();
    endtask

    task automatic test_load_use();
        idle(3);
        set_id(1, 1, 1, 2, 1, 0, 0, 7);           // lw x7
        tick();
        set_id(1, 1, 0, 7, 1, 7, 1, 8);           // add x8,x7,x7
        #1;
        $display("load_use: stall=%0b bubble=%0b cnt=%0d", bus.stall_if_id, bus.bubble_ex, bus.stall_cnt);
        n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_err++; $display("FAIL lu_stall: got %0b want 1", bus.stall_if_id); end
        n_cmp++; if (bus.bubble_ex !== 1'b1) begin n_err++; $display("FAIL lu_bubble: got %0b want 1", bus.bubble_ex); end
        n_cmp++; if (bus.fwd_rs1_sel !== '0 || bus.fwd_rs2_sel !== '0) begin n_err++; $display("FAIL lu_fwd_zero: got %0d/%0d want 0/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_cnt !== CNT_W'(0)) begin n_err++; $display("FAIL lu_cnt_before: got %0d want 0", bus.stall_cnt); end
        tick();
        #1;
        $display("load_use: retry sel=%0d/%0d cnt=%0d", bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.stall_cnt);
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL lu_release: got %0b want 0", bus.stall_if_id); end
        n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(2) || bus.fwd_rs2_sel !== SEL_W'(2)) begin n_err++; $display("FAIL lu_fwd2: got %0d/%0d want 2/2", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        n_cmp++; if (bus.stall_cnt !== CNT_W'(1)) begin n_err++; $display("FAIL lu_cnt_after: got %0d want 1", bus.stall_cnt); end
        tick();
    endtask

    task automatic test_youngest();
        idle(3);
        set_id(1, 1, 0, 0, 0, 0, 0, 9); tick();   // write x9 (ends in stage 3)
        set_id(1, 0, 0, 0, 0, 0, 0, 9); tick();   // non-writer
        set_id(1, 1, 0, 0, 0, 0, 0, 9); tick();   // write x9 (stage 1)
        set_id(1, 1, 0, 9, 1, 9, 1, 4);
        #1;
        $display("youngest: x9 consumer sel=%0d/%0d", bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(1)) begin n_err++; $display("FAIL young_rs1: got %0d want 1", bus.fwd_rs1_sel); end
        n_cmp++; if (bus.fwd_rs2_sel !== SEL_W'(1)) begin n_err++; $display("FAIL young_rs2: got %0d want 1", bus.fwd_rs2_sel); end
        tick();
        idle(3);
        set_id(1, 1, 0, 0, 0, 0, 0, 0); tick();   // producer with rd=x0
        set_id(1, 1, 0, 0, 1, 0, 1, 3);
        #1;
        $display("youngest: x0 consumer sel=%0d/%0d", bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        n_cmp++; if (bus.fwd_rs1_sel !== '0 || bus.fwd_rs2_sel !== '0) begin n_err++; $display("FAIL x0_fwd: got %0d/%0d want 0/0", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        tick();
        set_id(1, 1, 0, 0, 0, 0, 0, 3); tick();   // write x3
        set_id(1, 1, 0, 3, 0, 3, 1, 2);           // rs1 names x3 but is unused
        #1;
        $display("youngest: unused source sel=%0d/%0d", bus.fwd_rs1_sel, bus.fwd_rs2_sel);
        n_cmp++; if (bus.fwd_rs1_sel !== '0 || bus.fwd_rs2_sel !== SEL_W'(1)) begin n_err++; $display("FAIL unused_fwd: got %0d/%0d want 0/1", bus.fwd_rs1_sel, bus.fwd_rs2_sel); end
        tick();
    endtask

    task automatic test_flush_vs_load();
        int s0, f0;
        idle(3);
        set_id(1, 1, 1, 2, 1, 0, 0, 7); tick();   // lw x7
        set_id(1, 1, 0, 7, 1, 7, 1, 8);
        set_ctl(1, 0, 0);
        #1;
        $display("flush_vs_load: flush=%0b stall=%0b bubble=%0b", bus.flush, bus.stall_if_id, bus.bubble_ex);
        n_cmp++; if (bus.flush !== 1'b1) begin n_err++; $display("FAIL fvl_flush: got %0b want 1", bus.flush); end
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL fvl_stall: got %0b want 0", bus.stall_if_id); end
        n_cmp++; if (bus.bubble_ex !== 1'b0) begin n_err++; $display("FAIL fvl_bubble: got %0b want 0", bus.bubble_ex); end
        s0 = m_scnt; f0 = m_fcnt;
        tick();
        set_ctl(0, 0, 0);
        #1;
        $display("flush_vs_load: counts stall=%0d flush=%0d", bus.stall_cnt, bus.flush_cnt);
        n_cmp++; if (bus.flush_cnt !== CNT_W'(f0 + 1)) begin n_err++; $display("FAIL fvl_fcnt: got %0d want %0d", bus.flush_cnt, f0 + 1); end
        n_cmp++; if (bus.stall_cnt !== CNT_W'(s0)) begin n_err++; $display("FAIL fvl_scnt: got %0d want %0d", bus.stall_cnt, s0); end
        n_cmp++; if (bus.stall_if_id !== 1'b0 || bus.fwd_rs1_sel !== SEL_W'(2)) begin n_err++; $display("FAIL fvl_after: got stall=%0b sel=%0d want 0/2", bus.stall_if_id, bus.fwd_rs1_sel); end
        tick();
    endtask

    task automatic test_ext_stall_branch();
        int f0;
        idle(3);
        set_id(1, 1, 0, 0, 0, 0, 0, 11); tick();  // write x11
        set_id(1, 1, 0, 11, 1, 0, 0, 12);
        set_ctl(1, 1, 0);
        f0 = m_fcnt;
        for (int i = 0; i < 3; i++) begin
            #1;
            $display("ext_stall_branch: stall cycle %0d flush=%0b stall=%0b sel=%0d", i, bus.flush, bus.stall_if_id, bus.fwd_rs1_sel);
            n_cmp++; if (bus.flush !== 1'b0 || bus.bubble_ex !== 1'b0) begin n_err++; $display("FAIL esb_flush_held: got flush=%0b bubble=%0b want 0/0", bus.flush, bus.bubble_ex); end
            n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_err++; $display("FAIL esb_stall: got %0b want 1", bus.stall_if_id); end
            n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(1)) begin n_err++; $display("FAIL esb_hold: got %0d want 1", bus.fwd_rs1_sel); end
            tick();
        end
        set_ctl(1, 0, 0);
        #1;
        $display("ext_stall_branch: release flush=%0b", bus.flush);
        n_cmp++; if (bus.flush !== 1'b1 || bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL esb_flush_once: got flush=%0b stall=%0b want 1/0", bus.flush, bus.stall_if_id); end
        n_cmp++; if (bus.flush_cnt !== CNT_W'(f0)) begin n_err++; $display("FAIL esb_cnt_held: got %0d want %0d", bus.flush_cnt, f0); end
        tick();
        set_ctl(0, 0, 0);
        #1;
        $display("ext_stall_branch: after flush=%0b cnt=%0d", bus.flush, bus.flush_cnt);
        n_cmp++; if (bus.flush !== 1'b0) begin n_err++; $display("FAIL esb_after: got %0b want 0", bus.flush); end
        n_cmp++; if (bus.flush_cnt !== CNT_W'(f0 + 1)) begin n_err++; $display("FAIL esb_cnt: got %0d want %0d", bus.flush_cnt, f0 + 1); end
        n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(2)) begin n_err++; $display("FAIL esb_shift: got %0d want 2", bus.fwd_rs1_sel); end
        tick();
    endtask

    task automatic test_saturation_clear();
        idle(3);
        for (int i = 0; i < 17; i++) begin
            set_id(1, 1, 1, 1, 1, 0, 0, 7); tick();
            set_id(1, 1, 0, 7, 1, 0, 0, 8);
            #1;
            $display("saturation: event %0d stall_cnt=%0d", i, bus.stall_cnt);
            n_cmp++; if (bus.bubble_ex !== 1'b1 || bus.stall_cnt !== CNT_W'(m_scnt)) begin n_err++; $display("FAIL sat_step: got bubble=%0b cnt=%0d want 1/%0d", bus.bubble_ex, bus.stall_cnt, m_scnt); end
            tick();
            tick();
        end
        n_cmp++; if (bus.stall_cnt !== CNT_W'(CMAX)) begin n_err++; $display("FAIL sat_hold: got %0d want %0d", bus.stall_cnt, CMAX); end
        set_id(1, 1, 1, 1, 1, 0, 0, 7); tick();
        set_id(1, 1, 0, 7, 1, 0, 0, 8);
        set_ctl(0, 0, 1);
        #1;
        $display("saturation: load-use with cnt_clr bubble=%0b", bus.bubble_ex);
        n_cmp++; if (bus.bubble_ex !== 1'b1) begin n_err++; $display("FAIL clr_bubble: got %0b want 1", bus.bubble_ex); end
        tick();
        set_ctl(0, 0, 0);
        #1;
        n_cmp++; if (bus.stall_cnt !== '0 || bus.flush_cnt !== '0) begin n_err++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", bus.stall_cnt, bus.flush_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle(3);
        set_id(1, 1, 1, 1, 1, 0, 0, 7); tick();
        set_id(1, 1, 0, 7, 1, 7, 1, 8);
        #1;
        n_cmp++; if (bus.stall_if_id !== 1'b1) begin n_err++; $display("FAIL rms_pre: got %0b want 1", bus.stall_if_id); end
        rst = 1'b0;
        model_clear();
        #1;
        $display("reset_mid_stall: stall=%0b bubble=%0b", bus.stall_if_id, bus.bubble_ex);
        n_cmp++; if (bus.stall_if_id !== 1'b0 || bus.bubble_ex !== 1'b0 || bus.flush !== 1'b0) begin n_err++; $display("FAIL rms_out: got %0b%0b%0b want 000", bus.stall_if_id, bus.bubble_ex, bus.flush); end
        n_cmp++; if (bus.fwd_rs1_sel !== '0 || bus.stall_cnt !== '0) begin n_err++; $display("FAIL rms_fwd_cnt: got %0d/%0d want 0/0", bus.fwd_rs1_sel, bus.stall_cnt); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.stall_if_id !== 1'b0) begin n_err++; $display("FAIL rms_discard: got %0b want 0", bus.stall_if_id); end
        tick();
    endtask

    task automatic test_random();
        bit hold;
        hold = 0;
        idle(3);
        for (int i = 0; i < 300; i++) begin
            if (!hold)
                set_id($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                       $urandom_range(0, 3), $urandom_range(0, 3) != 0,
                       $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 3));
            set_ctl($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
            #1;
            model_eval();
            $display("rand %0d: v=%0b rs=%0d/%0d rd=%0d br=%0b es=%0b -> st=%0b bu=%0b fl=%0b sel=%0d/%0d cnt=%0d/%0d",
                     i, bus.id_valid, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.ex_branch_taken, bus.ext_stall,
                     bus.stall_if_id, bus.bubble_ex, bus.flush, bus.fwd_rs1_sel, bus.fwd_rs2_sel, bus.stall_cnt, bus.flush_cnt);
            n_cmp++; if (bus.stall_if_id !== exp_stall) begin n_err++; $display("FAIL rnd_stall %0d: got %0b want %0b", i, bus.stall_if_id, exp_stall); end
            n_cmp++; if (bus.bubble_ex !== exp_bubble) begin n_err++; $display("FAIL rnd_bubble %0d: got %0b want %0b", i, bus.bubble_ex, exp_bubble); end
            n_cmp++; if (bus.flush !== exp_flush) begin n_err++; $display("FAIL rnd_flush %0d: got %0b want %0b", i, bus.flush, exp_flush); end
            n_cmp++; if (bus.fwd_rs1_sel !== SEL_W'(exp_sel1)) begin n_err++; $display("FAIL rnd_sel1 %0d: got %0d want %0d", i, bus.fwd_rs1_sel, exp_sel1); end
            n_cmp++; if (bus.fwd_rs2_sel !== SEL_W'(exp_sel2)) begin n_err++; $display("FAIL rnd_sel2 %0d: got %0d want %0d", i, bus.fwd_rs2_sel, exp_sel2); end
            n_cmp++; if (bus.stall_cnt !== CNT_W'(m_scnt)) begin n_err++; $display("FAIL rnd_scnt %0d: got %0d want %0d", i, bus.stall_cnt, m_scnt); end
            n_cmp++; if (bus.flush_cnt !== CNT_W'(m_fcnt)) begin n_err++; $display("FAIL rnd_fcnt %0d: got %0d want %0d", i, bus.flush_cnt, m_fcnt); end
            hold = exp_stall;
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_forward();
        test_load_use();
        test_youngest();
        test_flush_vs_load();
        test_ext_stall_branch();
        test_saturation_clear();
        test_reset_mid_stall();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
